// File: rtl/adc_seq.sv
// ADC front-end sequencer: loads chip config after init, then runs one channel sweep per start.
// Optional macro ADC_SEQ_CALIB_EN appends a calibration burst to the config sequence.

module adc_seq #(
    parameter int unsigned NCH   = 32,
    parameter int unsigned CFG_N = 4,
    parameter int unsigned TMO   = 255
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 init,
    input  logic [16*CFG_N-1:0]  cfg_data,
    input  logic                 start,
    output logic                 busy,
    output logic                 cfg_ok,
    output logic                 err,
    output logic                 spi_fs,
    output logic [15:0]          spi_txd,
    input  logic                 spi_fd_spi,
    input  logic                 spi_fd_prd,
    input  logic [31:0]          spi_rxd,
    output logic                 out_valid,
    output logic [5:0]           out_ch,
    output logic [15:0]          out_a,
    output logic [15:0]          out_b,
    output logic                 sweep_done
);

    localparam int unsigned KW    = 7;
    localparam int unsigned WDW   = 8;
    localparam int unsigned CHW   = 6;
    localparam int unsigned DW    = 16;
    localparam int unsigned CAL_N = 10;

    typedef enum logic [2:0] {
        IDLE, CFG, SWP, ISSUE, WFD, WPRD, EMIT
`ifdef ADC_SEQ_CALIB_EN
        , CAL
`endif
    } state_e;

    typedef enum logic [1:0] {
        M_CFG, M_SWP
`ifdef ADC_SEQ_CALIB_EN
        , M_CAL
`endif
    } mode_e;

    state_e           state_q, state_d;
    mode_e            mode_q, mode_d;
    logic [KW-1:0]    k_q, k_d;
    logic [WDW-1:0]   wd_q, wd_d;
    logic [31:0]      rx_q, rx_d;
    logic             busy_q, busy_d;
    logic             cfg_ok_q, cfg_ok_d;
    logic             err_q, err_d;
    logic             fs_q, fs_d;
    logic [DW-1:0]    txd_q, txd_d;
    logic             out_valid_q, out_valid_d;
    logic [CHW-1:0]   out_ch_q, out_ch_d;
    logic [DW-1:0]    out_a_q, out_a_d;
    logic [DW-1:0]    out_b_q, out_b_d;
    logic             sweep_done_q, sweep_done_d;
    logic [DW-1:0]    cfg_word_c;

    // Select config word k without a variable part-select
    always_comb begin
        cfg_word_c = '0;
        for (int unsigned i = 0; i < CFG_N; i++) begin
            if (k_q == KW'(i)) cfg_word_c = cfg_data[16*i +: 16];
        end
    end

    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        k_d          = k_q;
        wd_d         = wd_q;
        rx_d         = rx_q;
        cfg_ok_d     = cfg_ok_q;
        err_d        = err_q;
        fs_d         = fs_q;
        txd_d        = txd_q;
        out_valid_d  = 1'b0;
        out_ch_d     = out_ch_q;
        out_a_d      = out_a_q;
        out_b_d      = out_b_q;
        sweep_done_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (init) begin
                    state_d  = CFG;
                    mode_d   = M_CFG;
                    k_d      = '0;
                    cfg_ok_d = 1'b0;
                    err_d    = 1'b0;
                end else if (start && cfg_ok_q) begin
                    state_d = SWP;
                    mode_d  = M_SWP;
                    k_d     = '0;
                end
            end
            CFG: begin
                txd_d   = cfg_word_c;
                fs_d    = 1'b1;
                state_d = ISSUE;
            end
`ifdef ADC_SEQ_CALIB_EN
            CAL: begin
                txd_d   = (k_q == '0) ? 16'h5500 : 16'hFF00;
                fs_d    = 1'b1;
                state_d = ISSUE;
            end
`endif
            SWP: begin
                txd_d   = (k_q < KW'(NCH)) ? {2'b00, k_q[5:0], 8'h00} : 16'hFF00;
                fs_d    = 1'b1;
                state_d = ISSUE;
            end
            ISSUE: begin
                wd_d    = '0;
                state_d = WFD;
            end
            WFD: begin
                if (spi_fd_spi) begin
                    rx_d    = spi_rxd;
                    fs_d    = 1'b0;
                    state_d = WPRD;
                end else if (wd_q == WDW'(TMO - 1)) begin
                    fs_d     = 1'b0;
                    err_d    = 1'b1;
                    cfg_ok_d = 1'b0;
                    state_d  = IDLE;
                end else begin
                    wd_d = wd_q + WDW'(1);
                end
            end
            WPRD: begin
                if (spi_fd_prd) begin
                    case (mode_q)
                        M_CFG: begin
                            if (k_q == KW'(CFG_N - 1)) begin
`ifdef ADC_SEQ_CALIB_EN
                                k_d     = '0;
                                mode_d  = M_CAL;
                                state_d = CAL;
`else
                                cfg_ok_d = 1'b1;
                                state_d  = IDLE;
`endif
                            end else begin
                                k_d     = k_q + KW'(1);
                                state_d = CFG;
                            end
                        end
`ifdef ADC_SEQ_CALIB_EN
                        M_CAL: begin
                            if (k_q == KW'(CAL_N - 1)) begin
                                cfg_ok_d = 1'b1;
                                state_d  = IDLE;
                            end else begin
                                k_d     = k_q + KW'(1);
                                state_d = CAL;
                            end
                        end
`endif
                        default: begin
                            // Chip pipeline lags two transactions: result k is channel k-2
                            if (k_q >= KW'(2)) begin
                                out_valid_d = 1'b1;
                                out_ch_d    = CHW'(k_q - KW'(2));
                                out_a_d     = rx_q[31:16];
                                out_b_d     = rx_q[15:0];
                                state_d     = EMIT;
                            end else begin
                                k_d     = k_q + KW'(1);
                                state_d = SWP;
                            end
                        end
                    endcase
                end
            end
            EMIT: begin
                if (k_q == KW'(NCH + 1)) begin
                    sweep_done_d = 1'b1;
                    state_d      = IDLE;
                end else begin
                    k_d     = k_q + KW'(1);
                    state_d = SWP;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            mode_q       <= M_CFG;
            k_q          <= '0;
            wd_q         <= '0;
            rx_q         <= '0;
            busy_q       <= 1'b0;
            cfg_ok_q     <= 1'b0;
            err_q        <= 1'b0;
            fs_q         <= 1'b0;
            txd_q        <= '0;
            out_valid_q  <= 1'b0;
            out_ch_q     <= '0;
            out_a_q      <= '0;
            out_b_q      <= '0;
            sweep_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            k_q          <= k_d;
            wd_q         <= wd_d;
            rx_q         <= rx_d;
            busy_q       <= busy_d;
            cfg_ok_q     <= cfg_ok_d;
            err_q        <= err_d;
            fs_q         <= fs_d;
            txd_q        <= txd_d;
            out_valid_q  <= out_valid_d;
            out_ch_q     <= out_ch_d;
            out_a_q      <= out_a_d;
            out_b_q      <= out_b_d;
            sweep_done_q <= sweep_done_d;
        end
    end

    assign busy       = busy_q;
    assign cfg_ok     = cfg_ok_q;
    assign err        = err_q;
    assign spi_fs     = fs_q;
    assign spi_txd    = txd_q;
    assign out_valid  = out_valid_q;
    assign out_ch     = out_ch_q;
    assign out_a      = out_a_q;
    assign out_b      = out_b_q;
    assign sweep_done = sweep_done_q;

endmodule

// File: tb/tb_adc_seq.sv
// Scoreboard bench for adc_seq: SPI engine model feeds results, queues hold expected txd and samples.

module tb_adc_seq;

    localparam int unsigned NCH   = 4;
    localparam int unsigned CFG_N = 4;
    localparam int unsigned TMO   = 255;
`ifdef ADC_SEQ_CALIB_EN
    localparam int CFG_TXN = 14;
`else
    localparam int CFG_TXN = 4;
`endif

    typedef struct {
        logic [5:0]  ch;
        logic [15:0] a;
        logic [15:0] b;
    } exp_t;

    logic                clk;
    logic                rst_n;
    logic                init;
    logic [16*CFG_N-1:0] cfg_data;
    logic                start;
    logic                busy;
    logic                cfg_ok;
    logic                err;
    logic                spi_fs;
    logic [15:0]         spi_txd;
    logic                spi_fd_spi;
    logic                spi_fd_prd;
    logic [31:0]         spi_rxd;
    logic                out_valid;
    logic [5:0]          out_ch;
    logic [15:0]         out_a;
    logic [15:0]         out_b;
    logic                sweep_done;

    int          chk_cnt = 0;
    int          pass_cnt = 0;
    int          cycle = 0;
    int          n_rise = 0;
    int          out_cnt = 0;
    int          done_cnt = 0;
    int          prd_cycle = -10;
    int          last_valid_cycle = -10;
    int          fs_run = 0;
    int          last_run = 0;
    bit          hang = 0;
    logic [15:0] exp_txd[$];
    exp_t        exp_out[$];

    adc_seq #(.NCH(NCH), .CFG_N(CFG_N), .TMO(TMO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .init       (init),
        .cfg_data   (cfg_data),
        .start      (start),
        .busy       (busy),
        .cfg_ok     (cfg_ok),
        .err        (err),
        .spi_fs     (spi_fs),
        .spi_txd    (spi_txd),
        .spi_fd_spi (spi_fd_spi),
        .spi_fd_prd (spi_fd_prd),
        .spi_rxd    (spi_rxd),
        .out_valid  (out_valid),
        .out_ch     (out_ch),
        .out_a      (out_a),
        .out_b      (out_b),
        .sweep_done (sweep_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic fail(input string name, input logic [31:0] act);
        chk_cnt++;
        $display("FAIL %s: got %h with nothing expected", name, act);
    endtask

    // SPI engine model: fd_spi 3 cycles after fs, holds until fs drops, then fd_prd pulse
    initial begin
        int          ph;
        int          cnt;
        logic [7:0]  eng_k;
        logic [7:0]  cur_k;
        ph = 0; cnt = 0; eng_k = '0; cur_k = '0;
        spi_fd_spi = 1'b0; spi_fd_prd = 1'b0; spi_rxd = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                spi_fd_spi = 1'b0; spi_fd_prd = 1'b0; ph = 0;
            end else begin
                case (ph)
                    0: if (spi_fs) begin
                        n_rise++;
                        if (exp_txd.size() == 0) fail("txd_extra", 32'(spi_txd));
                        else check("txd", 32'(spi_txd), 32'(exp_txd.pop_front()));
                        if (spi_txd == 16'h0000) eng_k = '0;
                        cur_k = eng_k;
                        eng_k = eng_k + 8'd1;
                        cnt = 0;
                        ph = 1;
                    end
                    1: if (!spi_fs) ph = 0;
                       else begin
                           cnt++;
                           if (cnt == 3 && !hang) begin
                               spi_rxd = {8'hA0 + cur_k, 8'h00, 8'hB0 + cur_k, 8'h00};
                               spi_fd_spi = 1'b1;
                               ph = 2;
                           end
                       end
                    2: if (!spi_fs) begin
                        spi_fd_spi = 1'b0;
                        cnt = 0;
                        ph = 3;
                    end
                    3: begin
                        cnt++;
                        if (cnt == 2) begin
                            spi_fd_prd = 1'b1;
                            prd_cycle = cycle;
                            ph = 4;
                        end
                    end
                    default: begin
                        spi_fd_prd = 1'b0;
                        ph = 0;
                    end
                endcase
            end
        end
    end

    // Output monitor: pops expected samples and checks strobe timing
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid) begin
                out_cnt++;
                check("valid_lat", 32'(cycle), 32'(prd_cycle + 1));
                if (exp_out.size() == 0) fail("out_extra", 32'(out_ch));
                else begin
                    exp_t e;
                    e = exp_out.pop_front();
                    check("out_ch", 32'(out_ch), 32'(e.ch));
                    check("out_a", 32'(out_a), 32'(e.a));
                    check("out_b", 32'(out_b), 32'(e.b));
                end
                last_valid_cycle = cycle;
            end
            if (sweep_done) begin
                done_cnt++;
                check("done_lat", 32'(cycle), 32'(last_valid_cycle + 1));
                check("done_busy", 32'(busy), 32'(0));
            end
        end
        if (spi_fs) fs_run++;
        else if (fs_run > 0) begin
            last_run = fs_run;
            fs_run = 0;
        end
    end

    task automatic pulse(input logic do_init, input logic do_start);
        @(negedge clk);
        init = do_init;
        start = do_start;
        @(negedge clk);
        init = 1'b0;
        start = 1'b0;
    endtask

    task automatic push_cfg();
        exp_txd.push_back(16'h8001);
        exp_txd.push_back(16'h8102);
        exp_txd.push_back(16'h8203);
        exp_txd.push_back(16'h8304);
`ifdef ADC_SEQ_CALIB_EN
        exp_txd.push_back(16'h5500);
        for (int i = 0; i < 9; i++) exp_txd.push_back(16'hFF00);
`endif
    endtask

    task automatic wait_cfg_ok(input string name);
        int n = 0;
        while (!cfg_ok && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(cfg_ok), 32'(1));
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'(0));
        check({tag, "_cfg_ok"}, 32'(cfg_ok), 32'(0));
        check({tag, "_err"}, 32'(err), 32'(0));
        check({tag, "_fs"}, 32'(spi_fs), 32'(0));
        check({tag, "_txd"}, 32'(spi_txd), 32'(0));
        check({tag, "_valid"}, 32'(out_valid), 32'(0));
        check({tag, "_ch"}, 32'(out_ch), 32'(0));
        check({tag, "_a"}, 32'(out_a), 32'(0));
        check({tag, "_b"}, 32'(out_b), 32'(0));
        check({tag, "_done"}, 32'(sweep_done), 32'(0));
    endtask

    task automatic ignored_start(input string tag);
        int   base;
        logic busy_hi;
        base = n_rise;
        busy_hi = 1'b0;
        pulse(1'b0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            busy_hi = busy_hi | busy;
        end
        check({tag, "_busy"}, 32'(busy_hi), 32'(0));
        check({tag, "_fs"}, 32'(n_rise - base), 32'(0));
    endtask

    task automatic run_sweep(input bit mid_start);
        int base, o0, d0, n;
        exp_t e;
        exp_txd.push_back(16'h0000);
        exp_txd.push_back(16'h0100);
        exp_txd.push_back(16'h0200);
        exp_txd.push_back(16'h0300);
        exp_txd.push_back(16'hFF00);
        exp_txd.push_back(16'hFF00);
        for (int c = 0; c < 4; c++) begin
            e.ch = 6'(c);
            e.a  = {8'hA2 + 8'(c), 8'h00};
            e.b  = {8'hB2 + 8'(c), 8'h00};
            exp_out.push_back(e);
        end
        base = n_rise; o0 = out_cnt; d0 = done_cnt;
        pulse(1'b0, 1'b1);
        check("start_lat1", 32'(spi_fs), 32'(0));
        @(negedge clk);
        check("start_lat2", 32'(spi_fs), 32'(1));
        if (mid_start) begin
            repeat (8) @(negedge clk);
            pulse(1'b0, 1'b1);
        end
        n = 0;
        while (done_cnt == d0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        repeat (20) @(negedge clk);
        check("sweep_done_cnt", 32'(done_cnt - d0), 32'(1));
        check("sweep_outs", 32'(out_cnt - o0), 32'(NCH));
        check("sweep_txn", 32'(n_rise - base), 32'(NCH + 2));
        check("sweep_txd_q", 32'(exp_txd.size()), 32'(0));
        check("sweep_out_q", 32'(exp_out.size()), 32'(0));
        check("sweep_busy", 32'(busy), 32'(0));
    endtask

    initial begin
        int   base, o0, d0, n;
        exp_t e;
        rst_n = 1'b1; init = 1'b0; start = 1'b0;
        cfg_data = {16'h8304, 16'h8203, 16'h8102, 16'h8001};
        #3 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        ignored_start("nocfg");

        // init and start together: only the config runs
        push_cfg();
        base = n_rise; o0 = out_cnt; d0 = done_cnt;
        pulse(1'b1, 1'b1);
        check("init_busy", 32'(busy), 32'(1));
        wait_cfg_ok("init_cfg_ok");
        repeat (10) @(negedge clk);
        check("init_txn", 32'(n_rise - base), 32'(CFG_TXN));
        check("init_txd_q", 32'(exp_txd.size()), 32'(0));
        check("init_no_out", 32'(out_cnt - o0), 32'(0));
        check("init_no_done", 32'(done_cnt - d0), 32'(0));
        check("init_err", 32'(err), 32'(0));

        run_sweep(1'b1);

        // engine never answers: watchdog fires
        hang = 1'b1;
        exp_txd.push_back(16'h0000);
        o0 = out_cnt; d0 = done_cnt;
        pulse(1'b0, 1'b1);
        n = 0;
        while (!err && n < 400) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        hang = 1'b0;
        check("tmo_err", 32'(err), 32'(1));
        check("tmo_cfg_ok", 32'(cfg_ok), 32'(0));
        check("tmo_fs", 32'(spi_fs), 32'(0));
        check("tmo_busy", 32'(busy), 32'(0));
        // fs high for the ISSUE cycle plus TMO watchdog cycles
        check("tmo_fs_len", 32'(last_run), 32'(TMO + 1));
        check("tmo_no_done", 32'(done_cnt - d0), 32'(0));
        check("tmo_no_out", 32'(out_cnt - o0), 32'(0));
        check("tmo_txd_q", 32'(exp_txd.size()), 32'(0));
        ignored_start("tmo_start");

        push_cfg();
        pulse(1'b1, 1'b0);
        check("reinit_err_clr", 32'(err), 32'(0));
        wait_cfg_ok("reinit_cfg_ok");
        check("reinit_err", 32'(err), 32'(0));

        // reset while waiting on transaction k=3
        exp_txd.push_back(16'h0000);
        exp_txd.push_back(16'h0100);
        exp_txd.push_back(16'h0200);
        exp_txd.push_back(16'h0300);
        e.ch = 6'd0; e.a = 16'hA200; e.b = 16'hB200;
        exp_out.push_back(e);
        base = n_rise; o0 = out_cnt;
        pulse(1'b0, 1'b1);
        n = 0;
        while (n_rise < base + 4 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("midrst_reach", 32'(n_rise - base), 32'(4));
        @(negedge clk);
        check("midrst_pre_fs", 32'(spi_fs), 32'(1));
        #2 rst_n = 1'b0;
        #1 check_zero("midrst");
        check("midrst_outs", 32'(out_cnt - o0), 32'(1));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check("midrst_txd_q", 32'(exp_txd.size()), 32'(0));
        check("midrst_out_q", 32'(exp_out.size()), 32'(0));
        ignored_start("postrst");

        push_cfg();
        pulse(1'b1, 1'b0);
        wait_cfg_ok("final_cfg_ok");
        run_sweep(1'b0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/adc_seq.md
# adc_seq

Sequencer for the ADC serial front end. It owns the existing SPI transaction engine: it loads the chip configuration once after `init`, then runs one channel sweep per `start` pulse. It drives the engine's `fs`/`chip_txd` and collects `chip_rxd`. It emits one 2×16-bit sample pair per channel to the packet builder and sits between the frame timer and the SPI engine in the ADC subsystem.

## Interface
- `NCH`, default 32: channels per sweep, 1..64.
- `CFG_N`, default 4: configuration words written during init, 1..16.
- `TMO`, default 255: cycles allowed from `spi_fs` rise to `spi_fd_spi`, 8-bit.

Ports:
- `clk` in 1: system clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `init` in 1: one-cycle pulse; runs the configuration sequence.
- `cfg_data` in 16*CFG_N: config command words; word i is `[16*i+15:16*i]`, sent in order i=0 first.
- `start` in 1: one-cycle pulse; runs one sweep.
- `busy` out 1: high in any state except IDLE.
- `cfg_ok` out 1: set when init completes; cleared by `init` or `err`.
- `err` out 1: sticky timeout flag; cleared only by `init`.
- `spi_fs` out 1: transaction request to the SPI engine.
- `spi_txd` out 16: command word for the SPI engine.
- `spi_fd_spi` in 1: engine frame-done level.
- `spi_fd_prd` in 1: engine period-done pulse.
- `spi_rxd` in 32: engine result; `[31:16]` is chip A, `[15:0]` is chip B.
- `out_valid` out 1: one-cycle sample strobe.
- `out_ch` out 6: channel of the current sample.
- `out_a` out 16, `out_b` out 16: chip A and chip B samples.
- `sweep_done` out 1: one-cycle pulse after the last sample of a sweep.

Reset values: every output is 0.

## Operation
States: IDLE, CFG, CAL, SWP, ISSUE, WFD, WPRD, EMIT.

- **IDLE**
  - `init` goes to CFG with k=0.
  - `start` goes to SWP with k=0 only when `cfg_ok`=1; otherwise `start` is ignored.
  - If `init` and `start` are high together, `init` wins.
  - Pulses that arrive while `busy` are dropped.
- **CFG**
  - Word k = `cfg_data` word k. Each word runs a transaction; its result is discarded.
  - After word CFG_N-1, go to CAL (macro set) or IDLE with `cfg_ok`←1.
- **SWP**, transaction k = 0..NCH+1. Command word:
  - k<NCH: CONVERT(k) = {2'b00, k[5:0], 8'h00}.
  - k≥NCH: dummy = 16'hFF00 (read reg 63).
  - The chip pipeline delays results by two transactions. Results for k<2 are discarded. Result k≥2 is emitted as channel k-2.
- **Transaction sub-sequence** (shared by all modes)
  - ISSUE: load `spi_txd`, set `spi_fs`←1, clear the watchdog.
  - WFD: wait for `spi_fd_spi`=1. On that cycle capture `spi_rxd`, drop `spi_fs`, go to WPRD.
  - WPRD: wait for the `spi_fd_prd` pulse. Then:
    - go to EMIT if this is a sweep result with k≥2;
    - otherwise increment k and issue the next transaction, or finish.
  - EMIT: `out_valid`=1 for one cycle with `out_ch`=k-2 and captured `out_a`/`out_b`, then advance.
- **Sweep end**: after the result of k=NCH+1 is emitted, pulse `sweep_done` and go to IDLE.
- **Watchdog**: counts cycles in WFD. When it reaches TMO:
  - drop `spi_fs`, set `err`, clear `cfg_ok`, go to IDLE;
  - emit no partial sample and no `sweep_done`.
- **Reset mid-operation**: everything returns to reset values and `spi_fs` drops immediately. The SPI engine must be reset in the same domain.

## Timing
- `spi_txd` is valid the same cycle `spi_fs` rises and is held stable until `spi_fs` falls. The engine samples it two cycles after it sees `fs`.
- `spi_fs` falls on the edge after `spi_fd_spi` is first seen high.
- The next `spi_fs` rise is no earlier than one cycle after the `spi_fd_prd` pulse.
- `out_valid` is asserted 1 cycle after the `spi_fd_prd` pulse that completed the transaction.
- `sweep_done` is asserted the cycle after the final `out_valid`.
- `busy` falls the same cycle as `sweep_done`.
- `start` latency: `spi_fs` rises 2 cycles after the `start` pulse (IDLE→SWP→ISSUE registered).
- Counter k is 7 bits; `out_ch` = k-2 truncated to 6 bits.

## Configuration
- Macro `ADC_SEQ_CALIB_EN`.
- Defined: after CFG, state CAL issues CALIBRATE 16'h5500 followed by 9 dummy commands 16'hFF00, all results discarded. `cfg_ok` is set after the 10th transaction.
- Undefined: CAL state and its logic are absent; CFG goes directly to IDLE.

## Test plan
- **Init**: `init` with CFG_N=4, words 16'h8001/8102/8203/8304, driven by the SPI engine model → exactly those 4 `spi_txd` values in order. `cfg_ok`=1, no `out_valid`. With `ADC_SEQ_CALIB_EN`, 16'h5500 then 9×16'hFF00 follow before `cfg_ok`.
- **Sweep**: NCH=4, model returns `{8'hA0+k, 8'h00, 8'hB0+k, 8'h00}` for transaction k.
  - Required txd sequence: 0000, 0100, 0200, 0300, FF00, FF00.
  - Required outputs: 4 `out_valid` with ch 0..3 and `out_a`=16'hA200..A500.
  - Then one `sweep_done`.
- **Start without config**: `start` before `init` → no `spi_fs`, `busy` stays 0. `start` pulsed during a sweep → ignored, exactly NCH samples.
- **Timeout**: model never raises `fd_spi` → `spi_fs` drops after 255 cycles, `err`=1, `cfg_ok`=0, no `sweep_done`. A following `init` clears `err`.
- **Reset mid-sweep**: assert `rst_n`=0 during WFD of k=3 → all outputs 0 on the same cycle. After release, `start` is ignored until `init` completes.
- **Simultaneous**: `init` and `start` high together in IDLE → the config sequence runs, no sweep.
